// File: rtl/exponential_unit.sv
// Sequential e^x for unsigned Q0.16 x, result Q2.16.
// Horner-form Taylor series sharing one multiplier.
module exponential_unit #(
  parameter int TERMS = 8,
  parameter int XW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [XW-1:0] x,
  output logic          done,
  output logic [1:0]    intpart,
  output logic [XW-1:0] fracpart
);

  typedef enum logic [1:0] {
    IDLE,
    MULX,
    MULC,
    DONE
  } state_t;

  localparam logic [XW+1:0] ONE = {2'b01, {XW{1'b0}}};

  state_t        state;
  logic          start_q;
  logic [XW-1:0] xr;
  logic [XW+1:0] acc;
  logic [XW+1:0] t;
  logic [3:0]    k;

  logic [XW:0]     rom [16];
  logic [2*XW+1:0] px;
  logic [2*XW+1:0] pc;
  logic            unused_lo;

  // c[k] = floor(2^XW / k), entry 0 never addressed
  for (genvar i = 0; i < 16; i++) begin : g_rom
    if (i == 0) begin : g_zero
      assign rom[i] = '0;
    end else begin : g_coef
      assign rom[i] = (XW+1)'((1 << XW) / i);
    end
  end

  assign px = {{XW{1'b0}}, acc} * {{(XW+2){1'b0}}, xr};
  assign pc = {{XW{1'b0}}, t} * {{(XW+1){1'b0}}, rom[k]};

  assign unused_lo = ^{px[XW-1:0], pc[XW-1:0]};

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      acc     <= '0;
      xr      <= '0;
      t       <= '0;
      k       <= '0;
      start_q <= 1'b0;
      done    <= 1'b0;
    end else begin
      start_q <= start;
      unique case (state)
        IDLE, DONE: begin
          if (start && !start_q) begin
            xr    <= x;
            acc   <= ONE;
            k     <= 4'(TERMS);
            done  <= 1'b0;
            state <= MULX;
          end
        end
        MULX: begin
          t     <= px[2*XW+1:XW];
          state <= MULC;
        end
        MULC: begin
          acc <= ONE + pc[2*XW+1:XW];
          k   <= k - 4'd1;
          if (k == 4'd1) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            state <= MULX;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign intpart  = acc[XW+1:XW];
  assign fracpart = acc[XW-1:0];

endmodule

// File: tb/tb_exponential_unit.sv
// Bench for exponential_unit: cycle model of
// handshake plus Horner arithmetic, and literals.
module tb_exponential_unit;

  localparam int TERMS = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] x = '0;
  logic        done;
  logic [1:0]  intpart;
  logic [15:0] fracpart;

  int n_chk = 0;
  int n_pass = 0;

  exponential_unit #(.TERMS(TERMS), .XW(16)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .x(x),
    .done(done),
    .intpart(intpart),
    .fracpart(fracpart)
  );

  always #5 clk = ~clk;

  // e^x = 1 + x(1 + x/2(1 + x/3(...))), truncating each step
  function automatic int unsigned model_exp(input int unsigned xv);
    longint unsigned a;
    longint unsigned p;
    a = 64'd65536;
    for (int kk = TERMS; kk >= 1; kk--) begin
      p = (a * xv) >> 16;
      a = 64'd65536 + ((p * longint'(65536 / kk)) >> 16);
    end
    return int'(a);
  endfunction

  task automatic check(input string nm,
                       input int unsigned act,
                       input int unsigned want);
    n_chk++;
    if (act == want) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h",
                  nm, act, want);
  endtask

  task automatic check_tol(input string nm,
                           input int unsigned act,
                           input int unsigned want,
                           input int tol);
    int d;
    d = int'(act) - int'(want);
    if (d < 0) d = -d;
    n_chk++;
    if (d <= tol) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h +/-%0d",
                  nm, act, want, tol);
  endtask

  // cycle-level reference of the handshake
  bit          chk_en = 0;
  bit          m_busy = 0;
  bit          m_done = 0;
  bit          m_prev = 0;
  int          m_cnt = 0;
  int unsigned m_val = 0;
  int unsigned m_pend = 0;

  always @(posedge clk) begin
    if (!rst) begin
      m_busy = 0;
      m_done = 0;
      m_val  = 0;
      m_prev = 0;
      m_cnt  = 0;
    end else begin
      if (start && !m_prev && !m_busy) begin
        m_busy = 1;
        m_done = 0;
        m_cnt  = 2 * TERMS;
        m_pend = model_exp(x);
      end else if (m_busy) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_busy = 0;
          m_done = 1;
          m_val  = m_pend;
        end
      end
      m_prev = start;
    end
    chk_en = 1;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_done", done, m_done);
      if (!m_busy)
        check("cyc_result", {intpart, fracpart}, m_val);
    end
  end

  task automatic run(input logic [15:0] xv,
                     input int hold,
                     input int glitch_at,
                     input int unsigned lit,
                     input int tol,
                     input string nm);
    int lat;
    int unsigned r;
    int unsigned mv;
    real e;
    x = xv;
    start = 1'b1;
    @(posedge clk);
    #1;
    x = ~xv;
    lat = 0;
    while (1) begin
      if (lat == hold - 1) start = 1'b0;
      if (glitch_at > 0 && lat == glitch_at) start = 1'b1;
      if (glitch_at > 0 && lat == glitch_at + 1) start = 1'b0;
      @(posedge clk);
      #1;
      lat++;
      if (done || lat > 40) break;
    end
    check({"latency_", nm}, lat, 16);
    r  = {intpart, fracpart};
    mv = model_exp(xv);
    check({"model_", nm}, r, mv);
    check_tol({"lit_", nm}, r, lit, tol);
    check_tol({"modlit_", nm}, mv, lit, tol);
    e = $exp(real'(xv) / 65536.0) * 65536.0;
    check_tol({"exp_", nm}, r, int'(e), 16);
  endtask

  initial begin
    int unsigned held;
    rst   = 1'b0;
    start = 1'b1;
    x     = 16'hE640;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_done", done, 0);
    check("rst_out", {intpart, fracpart}, 0);
    rst = 1'b1;

    run(16'hE640, 4, 0, 32'h27553, 16, "e640");
    run(16'h8000, 1, 0, 32'h1A612, 16, "8000");

    held = model_exp(16'h8000);
    x = 16'h1234;
    repeat (3) @(negedge clk);
    x = 16'hFFFF;
    repeat (2) @(negedge clk);
    check("hold_done", done, 1);
    check("hold_out", {intpart, fracpart}, held);

    run(16'h0000, 2, 0, 32'h10000, 0, "zero");
    run(16'h4CC0, 1, 6, 32'h15980, 16, "4cc0");
    run(16'h1980, 3, 9, 32'h11ACF, 16, "1980");

    // abort at cycle 7 of a computation
    x = 16'h8000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("abort_done", done, 0);
    check("abort_out", {intpart, fracpart}, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    run(16'hB300, 2, 0, 32'h20323, 16, "b300");

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
